timer_wb_arbiter: RTL and testbench
===================================

// Module: timer_wb_arbiter
// PURPOSE
//  N-master round-robin Wishbone arbiter sharing the single timer slave (counter/enable at addr 0,
//  compare value at addr 1) between CPU and other bus masters (e.g. DMA/debug).
//  Grants one master per transaction and forwards its cycle to the slave.
//  Returns the slave ack/read data to the owner, and aborts a hung transaction with an error pulse after a timeout.
// PARAMETERS
//  N_MST    2    number of masters (>=2)
//  ADDR_W   1    slave address width (timer uses 1)
//  TIMEOUT  16   cycles in BUSY without ack before error (>=4)
// PORTS
//  clk          in   1         clock, all state on posedge
//  rst          in   1         asynchronous, active-high reset
//  i_m_cyc      in   N_MST     per-master cycle request
//  i_m_we       in   N_MST     per-master write enable
//  i_m_adr      in   N_MST*ADDR_W  per-master address, master k at [k*ADDR_W +: ADDR_W]
//  i_m_dat      in   N_MST*32  per-master write data, master k at [k*32 +: 32]
//  o_m_rdt      out  32        read data, broadcast to all masters, valid with owner's ack
//  o_m_ack      out  N_MST     ack, only owner's bit can be 1
//  o_m_err      out  N_MST     1-cycle timeout error to owner
//  o_s_cyc      out  1         slave cycle
//  o_s_we       out  1         slave write enable
//  o_s_adr      out  ADDR_W    slave address
//  o_s_dat      out  32        slave write data
//  i_s_rdt      in   32        slave read data
//  i_s_ack      in   1         slave ack (1-cycle pulse)
//  o_busy       out  1         1 while in BUSY
//  o_owner      out  clog2(N_MST)  registered index of current/last owner
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, last=N_MST-1 (master 0 wins first), tmo_cnt=0.
//  Reset outputs: o_s_cyc=0, o_m_ack=0, o_m_err=0, o_busy=0.
//  IDLE:
//   - if any i_m_cyc, pick first requester scanning last+1, last+2, ... mod N_MST.
//   - register owner, go BUSY at next edge; else stay IDLE.
//  BUSY:
//   - o_s_cyc = i_m_cyc[owner], o_s_we/adr/dat = owner's signals (combinational mux on registered owner).
//   - o_m_ack[owner] = i_s_ack, o_m_rdt = i_s_rdt (combinational, 0 extra latency on return path).
//   - tmo_cnt increments every cycle, cleared on entry to BUSY.
//  BUSY exits (priority order, all to IDLE at next edge):
//   - i_s_ack=1: last<=owner.
//   - owner drops i_m_cyc before ack (abort): last<=owner, no ack/err issued, slave cyc drops same cycle.
//   - tmo_cnt==TIMEOUT-1: o_m_err[owner]=1 this cycle, last<=owner.
//  Never switch owner mid-transaction; non-owner requests wait in IDLE arbitration.
//  One-cycle IDLE gap between grants is mandatory: o_s_cyc is low >=1 cycle between transactions,
//  so the slave's toggling ack (ack<=cyc&~ack) restarts cleanly.
//  Latency, idle bus to timer slave: req cycle 0, o_s_cyc cycle 1, ack cycle 2.
//  Back-to-back same master with no competitor: one new transaction every 3 cycles.
//  Ack arriving with the timeout cycle: ack wins, no err.
//  Spurious i_s_ack in IDLE: ignored, no o_m_ack.
//  Reset asserted mid-BUSY: immediate IDLE, all outputs 0, no ack/err issued.
//  o_m_rdt = 0 when not BUSY.
// TESTING
//  1. M0 write adr=1 dat=32'h0000_0100 alone -> o_s_cyc c1, o_m_ack[0] c2, slave sees adr 1 dat 0x100.
//  2. M0,M1 both hold cyc from c0, 4 txns each -> grants 0,1,0,1..., never two acks same cycle.
//  3. Slave ack tied low, TIMEOUT=16 -> o_m_err[owner] pulse at 16th BUSY cycle, IDLE next, no ack.
//  4. M1 granted then drops cyc before ack -> IDLE next edge, no ack/err, M0 pending then granted.
//  5. rst pulse during BUSY with M1 owner -> outputs 0 asynchronously, first grant after reset goes to M0.
//  6. M0 read adr=0 with timer counting -> o_m_rdt equals i_s_rdt in the ack cycle, 0 elsewhere.

Source files
------------

// File: rtl/timer_wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one timer slave among N_MST masters; request->slave cyc 1 cycle.
// Return path (ack/rdt/err) is combinational in BUSY; losers simply hold cyc until granted.
module timer_wb_arbiter #(
  parameter int N_MST   = 2,
  parameter int ADDR_W  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MST-1:0]           i_m_cyc,
  input  logic [N_MST-1:0]           i_m_we,
  input  logic [N_MST*ADDR_W-1:0]    i_m_adr,
  input  logic [N_MST*32-1:0]        i_m_dat,
  output logic [31:0]                o_m_rdt,
  output logic [N_MST-1:0]           o_m_ack,
  output logic [N_MST-1:0]           o_m_err,
  output logic                       o_s_cyc,
  output logic                       o_s_we,
  output logic [ADDR_W-1:0]          o_s_adr,
  output logic [31:0]                o_s_dat,
  input  logic [31:0]                i_s_rdt,
  input  logic                       i_s_ack,
  output logic                       o_busy,
  output logic [$clog2(N_MST)-1:0]   o_owner
);

  localparam int OWN_W = $clog2(N_MST);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [OWN_W-1:0] LAST_IDX = OWN_W'(N_MST - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [OWN_W-1:0]  owner_q, owner_d;
  logic [OWN_W-1:0]  last_q, last_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

  logic [OWN_W-1:0]  pick;
  logic              pick_vld;
  logic [OWN_W-1:0]  cand;

  logic [N_MST-1:0]  own_sel;
  logic              own_cyc;
  logic              own_we;
  logic [ADDR_W-1:0] own_adr;
  logic [31:0]       own_dat;

  // Rotating scan starting just after the last owner, wrapping at N_MST-1.
  always_comb begin : arb
    pick     = '0;
    pick_vld = 1'b0;
    cand     = last_q;
    for (int i = 0; i < N_MST; i++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!pick_vld && i_m_cyc[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin : own_mux
    own_sel = '0;
    own_cyc = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    for (int k = 0; k < N_MST; k++) begin
      if (owner_q == OWN_W'(k)) begin
        own_sel[k] = 1'b1;
        own_cyc    = i_m_cyc[k];
        own_we     = i_m_we[k];
        own_adr    = i_m_adr[k*ADDR_W +: ADDR_W];
        own_dat    = i_m_dat[k*32 +: 32];
      end
    end
  end

  always_comb begin : fsm
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    tmo_cnt_d = tmo_cnt_q;
    o_s_cyc   = 1'b0;
    o_s_we    = 1'b0;
    o_s_adr   = '0;
    o_s_dat   = '0;
    o_m_rdt   = '0;
    o_m_ack   = '0;
    o_m_err   = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d   = pick;
          tmo_cnt_d = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        o_s_cyc = own_cyc;
        o_s_we  = own_we;
        o_s_adr = own_adr;
        o_s_dat = own_dat;
        o_m_rdt = i_s_rdt;
        o_m_ack = own_sel & {N_MST{i_s_ack}};
        // Ack beats abort beats timeout; every exit returns to IDLE for a mandatory gap.
        if (i_s_ack || !own_cyc) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (tmo_cnt_q == TMO_LAST) begin
          o_m_err = own_sel;
          state_d = IDLE;
          last_d  = owner_q;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy  = (state_q == BUSY);
  assign o_owner = owner_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= LAST_IDX;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_timer_wb_arbiter.sv
// Bench for timer_wb_arbiter: transaction-level arbiter model, toggling-ack timer slave, directed + random traffic.
module tb_timer_wb_arbiter;
  localparam int N   = 3;
  localparam int AW  = 1;
  localparam int TMO = 16;
  localparam int OW  = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    i_m_cyc, i_m_we;
  logic [N*AW-1:0] i_m_adr;
  logic [N*32-1:0] i_m_dat;
  logic [31:0]     o_m_rdt;
  logic [N-1:0]    o_m_ack, o_m_err;
  logic            o_s_cyc, o_s_we;
  logic [AW-1:0]   o_s_adr;
  logic [31:0]     o_s_dat;
  logic [31:0]     i_s_rdt;
  logic            i_s_ack;
  logic            o_busy;
  logic [OW-1:0]   o_owner;

  always #5 clk = ~clk;

  timer_wb_arbiter #(.N_MST(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_m_cyc(i_m_cyc), .i_m_we(i_m_we), .i_m_adr(i_m_adr), .i_m_dat(i_m_dat),
    .o_m_rdt(o_m_rdt), .o_m_ack(o_m_ack), .o_m_err(o_m_err),
    .o_s_cyc(o_s_cyc), .o_s_we(o_s_we), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
    .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  // master stimulus state
  logic [N-1:0]  mc, mw;
  logic [AW-1:0] ma [N];
  logic [31:0]   md [N];
  int            rem [N];
  int            drv_mode, slv_mode;

  // timer slave model
  logic          s_ack_r;
  logic [31:0]   s_rdt_r, timer, cmp;
  logic          s_cyc_s, s_we_s;
  logic [AW-1:0] s_adr_s;
  logic [31:0]   s_dat_s;
  logic [N-1:0]  seen_ack, seen_err;

  // arbiter reference model
  bit mb;
  int mo, ml, mcnt;

  // event logs, cycle numbers relative to t0
  int cyc_no, t0;
  int ack_cnt [N];
  int err_cnt, err_at;
  logic [N-1:0] err_vec;
  logic [31:0]  rdt_at_ack;
  int ack_at[$], scyc_at[$], grant_own[$], grant_at[$];
  bit prev_mb, prev_scyc;

  int n_chk, n_pass;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_no);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic apply();
    for (int k = 0; k < N; k++) begin
      i_m_adr[k*AW +: AW] = ma[k];
      i_m_dat[k*32 +: 32] = md[k];
    end
    i_m_cyc = mc;
    i_m_we  = mw;
  endtask

  task automatic new_txn(input int k);
    mc[k] = 1'b1;
    mw[k] = 1'($urandom_range(0, 1));
    ma[k] = AW'($urandom_range(0, 1));
    md[k] = $urandom();
  endtask

  task automatic clear_logs();
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    err_cnt = 0; err_at = -1; err_vec = '0; rdt_at_ack = 32'hffff_ffff;
    ack_at.delete(); scyc_at.delete(); grant_own.delete(); grant_at.delete();
    prev_mb = 0; prev_scyc = 0;
    t0 = cyc_no;
  endtask

  task automatic model_reset();
    mb = 0; mo = 0; ml = N - 1; mcnt = 0;
  endtask

  task automatic model_update();
    if (rst) model_reset();
    else if (!mb) begin
      if (i_m_cyc != '0) begin
        for (int i = 1; i <= N; i++) begin
          if (i_m_cyc[(ml + i) % N]) begin
            mo = (ml + i) % N;
            break;
          end
        end
        mb = 1; mcnt = 0;
      end
    end else if (i_s_ack || !i_m_cyc[mo] || mcnt == TMO - 1) begin
      mb = 0; ml = mo;
    end else mcnt++;
  endtask

  task automatic slave_update();
    logic [31:0] tn;
    tn = timer + 1;
    if (s_cyc_s && !s_ack_r) begin
      s_ack_r = 1'b1;
      if (s_we_s) begin
        s_rdt_r = '0;
        if (s_adr_s == '0) tn = s_dat_s; else cmp = s_dat_s;
      end else s_rdt_r = (s_adr_s == '0) ? timer : cmp;
    end else begin
      s_ack_r = 1'b0; s_rdt_r = '0;
    end
    timer = tn;
  endtask

  task automatic check();
    logic [N-1:0] e_ack, e_err;
    logic e_scyc;
    logic [31:0] e_rdt;
    e_ack  = '0;
    e_err  = '0;
    e_scyc = mb && i_m_cyc[mo];
    e_rdt  = mb ? i_s_rdt : 32'h0;
    if (mb && i_s_ack) e_ack[mo] = 1'b1;
    else if (mb && i_m_cyc[mo] && mcnt == TMO - 1) e_err[mo] = 1'b1;
    chk("busy", o_busy, mb);
    chk("owner", o_owner, mo);
    chk("s_cyc", o_s_cyc, e_scyc);
    chk("m_ack", o_m_ack, e_ack);
    chk("m_err", o_m_err, e_err);
    chk("m_rdt", o_m_rdt, e_rdt);
    if (e_scyc) begin
      chk("s_we", o_s_we, i_m_we[mo]);
      chk("s_adr", o_s_adr, i_m_adr[mo*AW +: AW]);
      chk("s_dat", o_s_dat, i_m_dat[mo*32 +: 32]);
    end
    if (mb && !prev_mb) begin grant_own.push_back(mo); grant_at.push_back(cyc_no - t0); end
    if (e_scyc && !prev_scyc) scyc_at.push_back(cyc_no - t0);
    if (e_ack != '0) begin ack_cnt[mo]++; ack_at.push_back(cyc_no - t0); rdt_at_ack = o_m_rdt; end
    if (e_err != '0) begin err_cnt++; err_at = cyc_no - t0; err_vec = e_err; end
    prev_mb = mb; prev_scyc = e_scyc;
    s_cyc_s = o_s_cyc; s_we_s = o_s_we; s_adr_s = o_s_adr; s_dat_s = o_s_dat;
    seen_ack = o_m_ack; seen_err = o_m_err;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (drv_mode == 0) begin
        if (mc[k] && (seen_ack[k] || seen_err[k])) begin
          rem[k]--;
          if (rem[k] > 0) new_txn(k);
        end
        mc[k] = (rem[k] > 0);
      end else if (drv_mode == 1) begin
        if (mc[k]) begin
          if (seen_ack[k] || seen_err[k]) begin
            if ($urandom_range(0, 1) == 1) new_txn(k); else mc[k] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) mc[k] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) new_txn(k);
      end
    end
    apply();
    case (slv_mode)
      0: begin i_s_ack = s_ack_r; i_s_rdt = s_rdt_r; end
      1: begin i_s_ack = ($urandom_range(0, 2) == 0); i_s_rdt = $urandom(); end
      2: begin i_s_ack = 1'b0; i_s_rdt = '0; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    model_update();
    slave_update();
    #1;
    drive();
    cyc_no++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mc = '0; mw = '0;
    for (int k = 0; k < N; k++) begin ma[k] = '0; md[k] = '0; rem[k] = 0; end
    apply();
    i_s_ack = 1'b0; i_s_rdt = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    s_ack_r = 1'b0; s_rdt_r = '0; timer = '0; cmp = '0;
    s_cyc_s = 1'b0; s_we_s = 1'b0; s_adr_s = '0; s_dat_s = '0;
    seen_ack = '0; seen_err = '0;
    clear_logs();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc_no = 0; drv_mode = 0; slv_mode = 0;
    mc = '0; mw = '0;
    for (int k = 0; k < N; k++) begin ma[k] = '0; md[k] = '0; rem[k] = 0; end
    apply();
    i_s_ack = 1'b0; i_s_rdt = '0;
    #2;
    chk("reset busy", o_busy, 0);
    chk("reset s_cyc", o_s_cyc, 0);
    chk("reset ack", o_m_ack, 0);
    chk("reset err", o_m_err, 0);
    chk("reset owner", o_owner, 0);

    // lone M0 write, then two more back-to-back
    do_reset();
    rem[0] = 3; mc[0] = 1'b1; mw[0] = 1'b1; ma[0] = 1'b1; md[0] = 32'h0000_0100; apply();
    repeat (3) step();
    chk("t1 slave cmp", cmp, 32'h100);
    repeat (9) step();
    chk("t1 s_cyc cycle", qget(scyc_at, 0), 1);
    chk("t1 ack cycle", qget(ack_at, 0), 2);
    chk("t1 2nd ack", qget(ack_at, 1), 5);
    chk("t1 3rd ack", qget(ack_at, 2), 8);
    chk("t1 2nd s_cyc", qget(scyc_at, 1), 4);
    chk("t1 ack count", ack_cnt[0], 3);

    // two masters competing, four transactions each
    do_reset();
    rem[0] = 4; rem[1] = 4; new_txn(0); new_txn(1); apply();
    repeat (30) step();
    chk("t2 grants", grant_own.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t2 grant%0d", i), qget(grant_own, i), i % 2);
    chk("t2 last grant cycle", qget(grant_at, 7), 22);
    chk("t2 acks m0", ack_cnt[0], 4);
    chk("t2 acks m1", ack_cnt[1], 4);

    // timeout with slave ack tied low
    do_reset();
    slv_mode = 2;
    rem[1] = 1; new_txn(1); apply();
    repeat (20) step();
    chk("t3 err cycle", err_at, 16);
    chk("t3 err vec", err_vec, 3'b010);
    chk("t3 err count", err_cnt, 1);
    chk("t3 acks", ack_cnt[0] + ack_cnt[1] + ack_cnt[2], 0);
    chk("t3 grants", grant_own.size(), 1);

    // ack on the timeout cycle, then spurious acks in IDLE
    do_reset();
    slv_mode = 3;
    rem[0] = 1; new_txn(0); apply();
    repeat (16) step();
    i_s_ack = 1'b1; i_s_rdt = 32'hdead_beef;
    step();
    i_s_ack = 1'b0; i_s_rdt = '0;
    repeat (2) step();
    i_s_ack = 1'b1;
    repeat (2) step();
    i_s_ack = 1'b0;
    chk("t3b ack cycle", qget(ack_at, 0), 16);
    chk("t3b no err", err_cnt, 0);
    chk("t3b ack count", ack_cnt[0], 1);
    chk("t3b rdt", rdt_at_ack, 32'hdead_beef);

    // M1 aborts, pending M0 granted afterwards
    do_reset();
    slv_mode = 2; drv_mode = 2;
    mc = 3'b010; md[1] = 32'h1111_1111; md[0] = 32'h2222_2222; apply();
    step();
    mc = 3'b011; apply();
    step();
    mc = 3'b001; apply();
    repeat (5) step();
    chk("t4 grant0", qget(grant_own, 0), 1);
    chk("t4 grant1", qget(grant_own, 1), 0);
    chk("t4 grant1 cycle", qget(grant_at, 1), 4);
    chk("t4 no ack", ack_cnt[0] + ack_cnt[1], 0);
    chk("t4 no err", err_cnt, 0);

    // reset pulse while M1 owns the bus
    do_reset();
    drv_mode = 0; slv_mode = 2;
    rem[1] = 1; new_txn(1); apply();
    repeat (3) step();
    chk("t5 model busy", mb, 1);
    chk("t5 model owner", mo, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5 busy async", o_busy, 0);
    chk("t5 s_cyc async", o_s_cyc, 0);
    chk("t5 ack async", o_m_ack, 0);
    chk("t5 err async", o_m_err, 0);
    chk("t5 owner async", o_owner, 0);
    model_reset();
    clear_logs();
    rem[0] = 1; new_txn(0); apply();
    step();
    rst = 1'b0;
    repeat (4) step();
    chk("t5 first grant", qget(grant_own, 0), 0);
    chk("t5 grant cycle", qget(grant_at, 0), 2);

    // M0 read of the running counter
    do_reset();
    slv_mode = 0; drv_mode = 0;
    rem[0] = 1; mc[0] = 1'b1; mw[0] = 1'b0; ma[0] = '0; md[0] = '0; apply();
    repeat (5) step();
    chk("t6 ack cycle", qget(ack_at, 0), 2);
    chk("t6 read data", rdt_at_ack, 32'd1);

    // random traffic
    do_reset();
    drv_mode = 1;
    for (int blk = 0; blk < 15; blk++) begin
      slv_mode = (blk % 5 == 4) ? 2 : (blk % 2);
      repeat (200) step();
    end
    chk("rand activity", grant_own.size() > 50, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
